// File: rtl/ss_universal_register_if.sv
// ----------------------------------------------------------------------------
// ss_universal_register_if
//   Bundles the control, data and status signals of ss_universal_register.
//
//   Signals:
//     en          clock enable; 0 holds all state
//     mode[2:0]   operation select
//     sin         serial data in
//     pin[W-1:0]  parallel load data
//     pout[W-1:0] register contents
//     sout        last bit shifted or rotated out
//     count[CW-1:0] shift/rotate ops completed in the current frame
//     frame_done  one-cycle pulse after a WIDTH-op frame completes
//
//   Modports:
//     master  drives the controls and reads status (the user of the register)
//     slave   the register itself
// ----------------------------------------------------------------------------
interface ss_universal_register_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH);

    logic             en;
    logic [2:0]       mode;
    logic             sin;
    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] pout;
    logic             sout;
    logic [CW-1:0]    count;
    logic             frame_done;

    modport master (
        output en, mode, sin, pin,
        input  pout, sout, count, frame_done
    );

    modport slave (
        input  en, mode, sin, pin,
        output pout, sout, count, frame_done
    );
endinterface

// File: rtl/ss_universal_register.sv
// ----------------------------------------------------------------------------
// ss_universal_register
//   WIDTH-bit universal shift register: shift left/right, rotate left/right,
//   arithmetic shift right, parallel load, clear. A frame counter counts
//   shift-class operations and pulses frame_done for one cycle each time
//   WIDTH of them have completed. All outputs are registered.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset (overrides en and mode)
//     bus    ss_universal_register_if.slave (en, mode, sin, pin in;
//            pout, sout, count, frame_done out)
// ----------------------------------------------------------------------------
module ss_universal_register #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ss_universal_register_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHL   = 3'b001,
        MODE_SHR   = 3'b010,
        MODE_ROL   = 3'b011,
        MODE_ROR   = 3'b100,
        MODE_LOAD  = 3'b101,
        MODE_ASR   = 3'b110,
        MODE_CLEAR = 3'b111
    } mode_e;

    mode_e            mode;
    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic [CW-1:0]    count_q, count_d;
    logic             done_q, done_d;
    logic             shift_op;

    assign mode = mode_e'(bus.mode);

    always_comb begin
        // NOTE: every signal gets a default before the case, so no path
        // leaves one unassigned and no latch is inferred.
        q_d      = q_q;
        sout_d   = sout_q;
        count_d  = count_q;
        done_d   = 1'b0;
        shift_op = 1'b0;

        if (bus.en) begin
            case (mode)
                MODE_HOLD: ;
                MODE_SHL: begin
                    q_d      = {q_q[WIDTH-2:0], bus.sin};
                    sout_d   = q_q[WIDTH-1];
                    shift_op = 1'b1;
                end
                MODE_SHR: begin
                    q_d      = {bus.sin, q_q[WIDTH-1:1]};
                    sout_d   = q_q[0];
                    shift_op = 1'b1;
                end
                MODE_ROL: begin
                    q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    sout_d   = q_q[WIDTH-1];
                    shift_op = 1'b1;
                end
                MODE_ROR: begin
                    q_d      = {q_q[0], q_q[WIDTH-1:1]};
                    sout_d   = q_q[0];
                    shift_op = 1'b1;
                end
                MODE_LOAD: begin
                    q_d     = bus.pin;
                    sout_d  = 1'b0;
                    count_d = '0;
                end
                MODE_ASR: begin
                    // Sign bit is replicated; sin plays no part.
                    q_d      = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                    sout_d   = q_q[0];
                    shift_op = 1'b1;
                end
                MODE_CLEAR: begin
                    q_d     = '0;
                    sout_d  = 1'b0;
                    count_d = '0;
                end
            endcase

            // Counter counts operations regardless of direction; the pulse
            // lands in the cycle right after the WIDTH-th op of a frame.
            if (shift_op) begin
                if (count_q == CW'(WIDTH - 1)) begin
                    count_d = '0;
                    done_d  = 1'b1;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
        end
    end

    // NOTE: reset is synchronous (sampled only on the clock edge), and all
    // state updates use non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q     <= '0;
            sout_q  <= 1'b0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            q_q     <= q_d;
            sout_q  <= sout_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign bus.pout       = q_q;
    assign bus.sout       = sout_q;
    assign bus.count      = count_q;
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_ss_universal_register.sv
// ----------------------------------------------------------------------------
// tb_ss_universal_register
//   Directed stimulus for ss_universal_register (WIDTH=8). A behavioural model
//   tracks the expected register value, serial output and frame position with
//   plain arithmetic; a compare process checks the DUT against it on every
//   falling edge. Literal expectations at key points pin the model itself.
// ----------------------------------------------------------------------------
module tb_ss_universal_register;
    localparam int W  = 8;
    localparam int CW = $clog2(W);

    logic clk;
    logic rst_n;

    ss_universal_register_if #(.WIDTH(W)) bus ();

    ss_universal_register #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [W-1:0] m_q;
    logic         m_sout;
    int           m_ops;     // ops completed in current frame
    logic         m_done;
    bit           compare_on = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_q = '0; m_sout = 1'b0; m_ops = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (bus.en) begin
                case (bus.mode)
                    3'd1: begin m_sout = m_q[W-1]; m_q = W'((m_q << 1) | W'(bus.sin)); end
                    3'd2: begin m_sout = m_q[0];   m_q = W'((m_q >> 1) | (W'(bus.sin) << (W-1))); end
                    3'd3: begin m_sout = m_q[W-1]; m_q = W'((m_q << 1) | (m_q >> (W-1))); end
                    3'd4: begin m_sout = m_q[0];   m_q = W'((m_q >> 1) | (m_q << (W-1))); end
                    3'd6: begin m_sout = m_q[0];   m_q = W'($signed(m_q) >>> 1); end
                    3'd5: begin m_q = bus.pin; m_sout = 1'b0; m_ops = 0; end
                    3'd7: begin m_q = '0;      m_sout = 1'b0; m_ops = 0; end
                    default: ;
                endcase
                if (bus.mode inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd6}) begin
                    m_ops  = (m_ops + 1) % W;
                    m_done = (m_ops == 0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (compare_on) begin
            check("model_pout",  32'(bus.pout),       32'(m_q));
            check("model_sout",  32'(bus.sout),       32'(m_sout));
            check("model_count", 32'(bus.count),      32'(m_ops));
            check("model_done",  32'(bus.frame_done), 32'(m_done));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step(input logic e, input logic [2:0] m, input logic s,
                        input logic [W-1:0] p, input logic r = 1'b1);
        rst_n    = r;
        bus.en   = e;
        bus.mode = m;
        bus.sin  = s;
        bus.pin  = p;
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] seq;
    int           pulses;

    initial begin
        rst_n = 1'b1; bus.en = 1'b0; bus.mode = 3'd0; bus.sin = 1'b0; bus.pin = '0;
        @(negedge clk);

        // Reset priority over an enabled load of FF
        step(1'b1, 3'd5, 1'b0, 8'hFF, 1'b0);
        check("rst_pout",  32'(bus.pout),       32'h00);
        check("rst_sout",  32'(bus.sout),       32'h0);
        check("rst_count", 32'(bus.count),      32'h0);
        check("rst_done",  32'(bus.frame_done), 32'h0);
        compare_on = 1'b1;

        // Serial out, shift left from A5
        step(1'b1, 3'd5, 1'b0, 8'hA5);
        seq = 8'hA5;
        for (int i = 0; i < W; i++) begin
            step(1'b1, 3'd1, 1'b0, '0);
            check("shl_sout",  32'(bus.sout),       32'(seq[W-1-i]));
            check("shl_count", 32'(bus.count),      32'((i + 1) % W));
            check("shl_done",  32'(bus.frame_done), 32'(i == W - 1));
        end
        check("shl_final_pout", 32'(bus.pout), 32'h00);

        // Rotate right
        step(1'b1, 3'd5, 1'b0, 8'h81);
        step(1'b1, 3'd4, 1'b0, '0);
        check("ror1_pout", 32'(bus.pout), 32'hC0);
        check("ror1_sout", 32'(bus.sout), 32'h1);
        pulses = 0;
        for (int i = 0; i < W - 1; i++) begin
            step(1'b1, 3'd4, 1'b0, '0);
            if (bus.frame_done) pulses++;
        end
        check("ror8_pout",   32'(bus.pout), 32'h81);
        check("ror8_pulses", 32'(pulses),   32'd1);

        // Arithmetic shift right
        step(1'b1, 3'd5, 1'b0, 8'h80);
        for (int i = 0; i < 3; i++) step(1'b1, 3'd6, 1'b0, '0);
        check("asr_neg_pout", 32'(bus.pout), 32'hF0);
        check("asr_neg_sout", 32'(bus.sout), 32'h0);
        step(1'b1, 3'd5, 1'b0, 8'h7F);
        step(1'b1, 3'd6, 1'b1, '0);
        check("asr_pos_pout", 32'(bus.pout), 32'h3F);
        check("asr_pos_sout", 32'(bus.sout), 32'h1);

        // Enable / hold gaps do not break a frame
        step(1'b1, 3'd5, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b1, 3'd1, 1'b1, '0);
        for (int i = 0; i < 3; i++) step(1'b0, 3'd1, 1'b0, '0);
        for (int i = 0; i < 2; i++) step(1'b1, 3'd0, 1'b0, '0);
        check("gap_count", 32'(bus.count),      32'd4);
        check("gap_done",  32'(bus.frame_done), 32'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 3'd2, 1'b0, '0);
        check("gap_wrap_done",  32'(bus.frame_done), 32'h1);
        check("gap_wrap_count", 32'(bus.count),      32'd0);

        // Load at count=5 aborts the frame
        for (int i = 0; i < 5; i++) step(1'b1, 3'd1, 1'b0, '0);
        step(1'b1, 3'd5, 1'b0, 8'h3C);
        check("abort_count", 32'(bus.count), 32'd0);
        for (int i = 0; i < W - 1; i++) step(1'b1, 3'd3, 1'b0, '0);
        check("abort_7_done", 32'(bus.frame_done), 32'h0);
        step(1'b1, 3'd3, 1'b0, '0);
        check("abort_8_done", 32'(bus.frame_done), 32'h1);

        // Load on a would-be wrap wins
        for (int i = 0; i < W - 1; i++) step(1'b1, 3'd1, 1'b0, '0);
        step(1'b1, 3'd5, 1'b0, 8'h5A);
        check("ldwrap_done",  32'(bus.frame_done), 32'h0);
        check("ldwrap_count", 32'(bus.count),      32'd0);

        // Back-to-back frames
        pulses = 0;
        for (int i = 0; i < 2 * W; i++) begin
            step(1'b1, 3'd2, 1'b0, '0);
            if (bus.frame_done) pulses++;
        end
        check("b2b_pulses", 32'(pulses), 32'd2);

        // Mid-frame reset
        step(1'b1, 3'd7, 1'b0, '0);
        for (int i = 0; i < 5; i++) step(1'b1, 3'd1, 1'b1, '0);
        check("pre_rst_pout", 32'(bus.pout), 32'h1F);
        step(1'b1, 3'd1, 1'b1, '0, 1'b0);
        check("mid_rst_pout",  32'(bus.pout),  32'h00);
        check("mid_rst_count", 32'(bus.count), 32'd0);
        for (int i = 0; i < W - 1; i++) step(1'b1, 3'd1, 1'b1, '0);
        check("post_rst_7_done", 32'(bus.frame_done), 32'h0);
        step(1'b1, 3'd1, 1'b1, '0);
        check("post_rst_8_done", 32'(bus.frame_done), 32'h1);
        check("post_rst_pout",   32'(bus.pout),       32'hFF);

        step(1'b1, 3'd0, 1'b0, '0);
        @(negedge clk);
        compare_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
